// File: rtl/tx_pkg.sv
// Shared link definitions for the router serial links.
//
// Flit width comes from the global PAYLOAD_SIZE / ADDR_SZ defines. When the
// global defines file has not been read first, fall back to the default
// 8-bit payload with 4-bit address so this slice stays self-contained.
//
// Contents:
//   FlitW       - serial frame data width (payload + address)
//   CntW        - bit-counter width for one frame, no wrap within a frame
//   LinkIdle/LinkData/LinkDrain - transmitter state encodings
//   tx_state_e  - transmitter FSM state type

`ifndef PAYLOAD_SIZE
`define PAYLOAD_SIZE 8
`endif

`ifndef ADDR_SZ
`define ADDR_SZ 4
`endif

package tx_pkg;

  localparam int unsigned FlitW = `PAYLOAD_SIZE + `ADDR_SZ;
  localparam int unsigned CntW  = $clog2(FlitW) + 1;

  // Transmitter state encodings, kept next to the receiver's state meanings
  // so both ends of a link read the same numbers in waveforms.
  localparam logic [1:0] LinkIdle  = 2'd0;
  localparam logic [1:0] LinkData  = 2'd1;
  localparam logic [1:0] LinkDrain = 2'd2;

  typedef enum logic [1:0] {
    StIdle  = LinkIdle,
    StData  = LinkData,
    StDrain = LinkDrain
  } tx_state_e;

endpackage

// File: rtl/tx.sv
// Parallel-to-serial link transmitter.
//
// Takes one flit (address + payload) from the router output logic and sends
// it on a 1-bit line as: one high start bit, then FlitW data bits, LSB first,
// then at least one low cycle. A holding register lets one flit wait while
// another is on the wire. Downstream flow control is the receiver's
// channel_busy, sampled only when idle or draining.
//
// Ports:
//   clk          - clock
//   reset        - asynchronous, active-high reset
//   req          - producer offers parallel_in this cycle
//   parallel_in  - flit to send; bit 0 goes out first
//   ready        - holding register empty; accept happens on edge with req & ready
//   channel_busy - downstream receiver busy (receiving or holding a flit)
//   serial_out   - registered serial line, idles low
//   active       - a frame is in flight or waiting for the receiver to drain

module tx
  import tx_pkg::*;
#(
  parameter int    routerid = -1,
  parameter string port     = "unknown"
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic [FlitW-1:0] parallel_in,
  output logic             ready,
  input  logic             channel_busy,
  output logic             serial_out,
  output logic             active
);

  tx_state_e        state;
  logic [FlitW-1:0] hold;
  logic             hold_valid;
  logic [FlitW-1:0] shreg;
  logic [CntW-1:0]  cnt;

  logic accept;
  logic launch;
  logic last_bit;

  assign ready    = !hold_valid;
  assign active   = (state != StIdle);
  assign accept   = req && ready;
  assign launch   = (state == StIdle) && hold_valid && !channel_busy;
  assign last_bit = (cnt == CntW'(FlitW - 1));

  // Accept and launch never collide: launch needs hold_valid, accept needs
  // !hold_valid, so hold_valid has a single writer per edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= StIdle;
      hold       <= '0;
      hold_valid <= 1'b0;
      shreg      <= '0;
      cnt        <= '0;
      serial_out <= 1'b0;
    end else begin
      if (accept) begin
        hold       <= parallel_in;
        hold_valid <= 1'b1;
      end

      unique case (state)
        StIdle: begin
          serial_out <= 1'b0;
          if (launch) begin
            serial_out <= 1'b1;  // start bit
            shreg      <= hold;
            hold_valid <= 1'b0;
            cnt        <= '0;
            state      <= StData;
          end
        end

        StData: begin
          // channel_busy is deliberately ignored mid-frame.
          serial_out <= shreg[0];
          shreg      <= shreg >> 1;
          cnt        <= cnt + 1'b1;
          if (last_bit) begin
            state <= StDrain;
          end
        end

        StDrain: begin
          // Line goes low immediately; hold here until the receiver has
          // handed its flit off so the next start bit is not lost.
          serial_out <= 1'b0;
          if (!channel_busy) begin
            state <= StIdle;
          end
        end

        default: begin
          serial_out <= 1'b0;
          state      <= StIdle;
        end
      endcase
    end
  end

  // A waiting flit on a free, idle link must show its start bit next cycle.
  assert property (@(posedge clk) disable iff (reset) launch |=> serial_out)
    else $error("tx router %0d port %s: start bit missing after launch", routerid, port);

endmodule

// File: tb/tb_tx.sv
// Directed bench for the link transmitter. A small behavioural receiver model
// decodes the line and produces channel_busy; the bench can also force the
// channel busy on its own.

module tb_tx;
  import tx_pkg::*;

  localparam int W = FlitW;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req = 1'b0;
  logic [W-1:0] parallel_in = '0;
  logic         ready;
  logic         channel_busy;
  logic         serial_out;
  logic         active;

  logic         force_busy = 1'b0;
  logic         item_read = 1'b0;

  // Receiver model state
  logic         rx_busy;
  logic         rx_rcv;
  logic         rx_pend;
  logic         rx_valid;
  logic [W-1:0] rx_sh;
  logic [W-1:0] rx_data;
  int           rx_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign channel_busy = rx_busy | force_busy;

  tx #(
    .routerid(0),
    .port    ("east")
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .parallel_in (parallel_in),
    .ready       (ready),
    .channel_busy(channel_busy),
    .serial_out  (serial_out),
    .active      (active)
  );

  // Receiver: busy the cycle after the start bit, W data bits LSB first,
  // valid W+2 cycles after the start bit cycle, cleared by item_read.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_busy  <= 1'b0;
      rx_rcv   <= 1'b0;
      rx_pend  <= 1'b0;
      rx_valid <= 1'b0;
      rx_sh    <= '0;
      rx_data  <= '0;
      rx_cnt   <= 0;
    end else begin
      if (rx_valid && item_read) begin
        rx_valid <= 1'b0;
        rx_busy  <= 1'b0;
      end
      if (!rx_busy && serial_out) begin
        rx_busy <= 1'b1;
        rx_rcv  <= 1'b1;
        rx_cnt  <= 0;
      end else if (rx_rcv) begin
        rx_sh  <= {serial_out, rx_sh[W-1:1]};
        rx_cnt <= rx_cnt + 1;
        if (rx_cnt == W - 1) begin
          rx_rcv  <= 1'b0;
          rx_pend <= 1'b1;
        end
      end else if (rx_pend) begin
        rx_pend  <= 1'b0;
        rx_valid <= 1'b1;
        rx_data  <= rx_sh;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic send(input logic [W-1:0] d);
    req         = 1'b1;
    parallel_in = d;
    tick();
    req         = 1'b0;
  endtask

  task automatic read_item();
    item_read = 1'b1;
    tick();
    item_read = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!rx_valid && n < 40) begin
      tick();
      n++;
    end
    check(tag, rx_valid, 1'b1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (active && n < 40) begin
      tick();
      n++;
    end
    check(tag, active, 1'b0);
  endtask

  initial begin
    logic [W-1:0] exp_flit;
    logic         saw_high;

    // Reset state
    repeat (2) tick();
    check("rst_serial", serial_out, 1'b0);
    check("rst_ready", ready, 1'b1);
    check("rst_active", active, 1'b0);
    reset = 1'b0;
    tick();
    check("rst_rel_ready", ready, 1'b1);

    // Single frame 12'hA5C, exact line sequence and receiver timing
    exp_flit = 12'hA5C;
    send(exp_flit);
    check("t1_ready_low", ready, 1'b0);
    check("t1_active_idle", active, 1'b0);
    check("t1_line_idle", serial_out, 1'b0);
    tick();
    check("t1_start", serial_out, 1'b1);
    check("t1_ready_back", ready, 1'b1);
    check("t1_active", active, 1'b1);
    for (int i = 0; i < W; i++) begin
      tick();
      check("t1_bit", serial_out, exp_flit[i]);
    end
    tick();
    check("t1_stop", serial_out, 1'b0);
    check("t1_valid_early", rx_valid, 1'b0);
    check("t1_drain_active", active, 1'b1);
    tick();
    check("t1_valid_at_14", rx_valid, 1'b1);
    check("t1_rx_data", rx_data, 12'hA5C);
    check("t1_busy_before_read", channel_busy, 1'b1);
    read_item();
    check("t1_busy_falls", channel_busy, 1'b0);
    check("t1_still_drain", active, 1'b1);
    tick();
    check("t1_back_idle", active, 1'b0);

    // Loopback 12'h3F1
    send(12'h3F1);
    wait_valid("t2_valid");
    check("t2_rx_data", rx_data, 12'h3F1);
    read_item();
    check("t2_busy_falls", channel_busy, 1'b0);
    wait_idle("t2_idle");

    // Back-to-back 12'h001 then 12'hFFE, read delayed 5 cycles
    send(12'h001);
    tick();
    check("t3_start1", serial_out, 1'b1);
    req         = 1'b1;
    parallel_in = 12'hFFE;
    tick();
    req         = 1'b0;
    check("t3_accept_in_data", ready, 1'b0);
    check("t3_in_data", active, 1'b1);
    check("t3_bit0", serial_out, 1'b1);
    wait_valid("t3_valid1");
    check("t3_rx_first", rx_data, 12'h001);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3_line_quiet", serial_out, 1'b0);
    end
    check("t3_busy_held", channel_busy, 1'b1);
    read_item();
    check("t3_busy_fell", channel_busy, 1'b0);
    check("t3_quiet_at_fall", serial_out, 1'b0);
    tick();
    check("t3_quiet_idle", serial_out, 1'b0);
    tick();
    check("t3_start2", serial_out, 1'b1);
    check("t3_ready2", ready, 1'b1);
    wait_valid("t3_valid2");
    check("t3_rx_second", rx_data, 12'hFFE);
    read_item();
    wait_idle("t3_idle");

    // Channel held busy with a flit waiting
    force_busy = 1'b1;
    send(12'h3A7);
    saw_high = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      saw_high = saw_high | serial_out;
    end
    check("t4_no_start", saw_high, 1'b0);
    check("t4_active", active, 1'b0);
    check("t4_ready", ready, 1'b0);
    force_busy = 1'b0;
    tick();
    check("t4_start_after_drop", serial_out, 1'b1);
    wait_valid("t4_valid");
    check("t4_rx_data", rx_data, 12'h3A7);
    read_item();
    wait_idle("t4_idle");

    // Reset during data bit 5
    send(12'h0F0);
    tick();
    for (int i = 0; i < 6; i++) tick();
    check("t5_bit5", serial_out, 1'b1);
    #1 reset = 1'b1;
    #1;
    check("t5_rst_serial", serial_out, 1'b0);
    check("t5_rst_ready", ready, 1'b1);
    check("t5_rst_active", active, 1'b0);
    #1 reset = 1'b0;
    tick();
    send(12'h555);
    wait_valid("t5_valid");
    check("t5_rx_data", rx_data, 12'h555);
    read_item();
    wait_idle("t5_idle");

    // req held high with changing data while the holding register is full
    force_busy  = 1'b1;
    send(12'h123);
    req = 1'b1;
    parallel_in = 12'hABC;
    tick();
    check("t6_ready_full", ready, 1'b0);
    parallel_in = 12'h0FF;
    tick();
    parallel_in = 12'h800;
    tick();
    parallel_in = 12'h7E7;
    tick();
    check("t6_still_full", ready, 1'b0);
    req        = 1'b0;
    force_busy = 1'b0;
    tick();
    check("t6_start", serial_out, 1'b1);
    wait_valid("t6_valid");
    check("t6_rx_data", rx_data, 12'h123);
    read_item();
    wait_idle("t6_idle");
    saw_high = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      saw_high = saw_high | serial_out;
    end
    check("t6_no_extra_frame", saw_high, 1'b0);
    check("t6_no_extra_valid", rx_valid, 1'b0);
    check("t6_ready_end", ready, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
